// File: rtl/aes_key_expand_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand_if
// Purpose  : Request / round-key stream bundle for aes_key_expand.
//            start/key_in request an expansion; rk_out/rk_idx/rk_valid and
//            rk_ready form the round-key handshake; busy/done report status.
// Modports : slave  - the key expander (drives round keys and status)
//            master - the requester / round-key consumer
// Revision : 1.0 - initial release
// ============================================================================
interface aes_key_expand_if;
    logic           start;      // request expansion of key_in
    logic [0:127]   key_in;     // cipher key, byte 0 = bits 0:7
    logic [0:127]   rk_out;     // current round key, same ordering
    logic [3:0]     rk_idx;     // round number of rk_out
    logic           rk_valid;   // rk_out / rk_idx valid
    logic           rk_ready;   // consumer accepts the round key
    logic           busy;       // expander not idle
    logic           done;       // one-cycle pulse after the last key

    modport slave (
        input  start, key_in, rk_ready,
        output rk_out, rk_idx, rk_valid, busy, done
    );

    modport master (
        output start, key_in, rk_ready,
        input  rk_out, rk_idx, rk_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand (with byte S-box SubBytes)
// Purpose  : AES-128 key schedule. Streams the 11 round keys over a
//            valid/ready handshake, one key per cycle when not stalled.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            kx (slave) - start, key_in, rk_ready in;
//                         rk_out, rk_idx, rk_valid, busy, done out
// Config   : AES_KEY_EXPAND_REVERSE_EN - when defined, all round keys are
//            precomputed into an 11-entry buffer (EXPAND state) and emitted
//            10 down to 0 for decryption. Undefined: forward streaming.
// Revision : 1.0 - initial release
// ============================================================================

// Byte substitution: one AES S-box lookup.
module SubBytes (
    output logic [7:0] o_byte,
    input  wire  [7:0] i_byte
);
    // Entry x occupies bits 8x..8x+7 (first listed byte is entry 0x00).
    localparam logic [0:2047] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = c_sbox[{i_byte, 3'b000} +: 8];
endmodule

module aes_key_expand (
    input  wire          clk,
    input  wire          rst_n,
    aes_key_expand_if.slave kx
);
    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_emit   = 2'd1;
`ifdef AES_KEY_EXPAND_REVERSE_EN
    localparam logic [1:0] c_expand = 2'd2;
    // Decryption order ends on round 0.
    localparam logic [3:0] c_last_idx = 4'd0;
`else
    localparam logic [3:0] c_last_idx = 4'd10;
`endif

    logic [1:0]   r_state;
    logic [0:127] r_key;     // working key; also the rk_out register
    logic [3:0]   r_idx;
    logic [7:0]   r_rcon;
    logic         r_done;

    logic [0:31]  w_rot;
    logic [0:31]  w_sub;
    logic [0:31]  w_t;
    logic [0:127] w_next_key;
    logic [7:0]   w_rcon_next;

    // RotWord of the last word of the current round key.
    assign w_rot = {r_key[104:127], r_key[96:103]};

    // SubWord: one S-box per byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
        SubBytes u_sb (
            .o_byte (w_sub[gi*8 +: 8]),
            .i_byte (w_rot[gi*8 +: 8])
        );
    end

    assign w_t = w_sub ^ {r_rcon, 24'h000000};

    // Each new word chains off the previous new word.
    assign w_next_key[0:31]   = r_key[0:31]   ^ w_t;
    assign w_next_key[32:63]  = r_key[32:63]  ^ w_next_key[0:31];
    assign w_next_key[64:95]  = r_key[64:95]  ^ w_next_key[32:63];
    assign w_next_key[96:127] = r_key[96:127] ^ w_next_key[64:95];

    // xtime in GF(2^8): 0x80 steps to 0x1b.
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

`ifdef AES_KEY_EXPAND_REVERSE_EN
    logic [0:127] r_buf [0:10];

    // Round i is written while r_idx = i during EXPAND.
    always_ff @(posedge clk) begin
        if (r_state == c_expand) begin
            r_buf[r_idx] <= r_key;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_key   <= '0;
            r_idx   <= 4'd0;
            r_rcon  <= 8'h01;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (kx.start) begin
                        r_key  <= kx.key_in;
                        r_idx  <= 4'd0;
                        r_rcon <= 8'h01;
`ifdef AES_KEY_EXPAND_REVERSE_EN
                        r_state <= c_expand;
`else
                        r_state <= c_emit;
`endif
                    end
                end
`ifdef AES_KEY_EXPAND_REVERSE_EN
                c_expand: begin
                    // On the last write r_key already holds round 10, which
                    // is the first key emitted, so it is simply kept.
                    if (r_idx == 4'd10) begin
                        r_state <= c_emit;
                    end else begin
                        r_key  <= w_next_key;
                        r_idx  <= r_idx + 4'd1;
                        r_rcon <= w_rcon_next;
                    end
                end
`endif
                c_emit: begin
                    if (kx.rk_ready) begin
                        if (r_idx == c_last_idx) begin
                            r_state <= c_idle;
                            r_done  <= 1'b1;
                        end else begin
`ifdef AES_KEY_EXPAND_REVERSE_EN
                            r_key <= r_buf[r_idx - 4'd1];
                            r_idx <= r_idx - 4'd1;
`else
                            r_key  <= w_next_key;
                            r_idx  <= r_idx + 4'd1;
                            r_rcon <= w_rcon_next;
`endif
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign kx.rk_out   = r_key;
    assign kx.rk_idx   = r_idx;
    assign kx.rk_valid = (r_state == c_emit);
    assign kx.busy     = (r_state != c_idle);
    assign kx.done     = r_done;
endmodule
`default_nettype wire

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request expansion of key_in; sampled only in IDLE.
REQ-004 SHALL have port key_in, input, [0:127]: cipher key, big-endian; byte 0 = bits 0:7, word 0 = bits 0:31.
REQ-005 SHALL have port rk_out, output, [0:127]: current round key, same byte and word ordering as key_in.
REQ-006 SHALL have port rk_idx, output, 4 bits: round number 0..10 of rk_out.
REQ-007 SHALL have port rk_valid, output, 1 bit: rk_out and rk_idx are valid.
REQ-008 SHALL have port rk_ready, input, 1 bit: the consumer accepts the key; handshake completes when rk_valid and rk_ready are both 1.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after round 10 is accepted.

Function
REQ-011 SHALL implement the AES-128 FIPS-197 schedule: w[i] = w[i-4] ^ SubWord(RotWord(w[i-1])) ^ Rcon for i mod 4 = 0, otherwise w[i] = w[i-4] ^ w[i-1].
REQ-012 SHALL build SubWord from 4 instances of the existing SubBytes byte-substitution module, port order (output, input); no second S-box table.
REQ-013 SHALL hold Rcon in a register stepped 01,02,04,08,10,20,40,80,1B,36 (xtime: shift left, XOR 1B on carry out), reset and reload value 01.
REQ-014 SHALL use the states IDLE, EXPAND and EMIT; EXPAND exists only under REQ-024.
REQ-015 In forward mode, SHALL load key_in in the cycle where IDLE and start=1 are sampled, go to EMIT, and show rk_valid=1, rk_idx=0, rk_out=key_in from the next cycle (latency 1).
REQ-016 In EMIT, SHALL hold rk_out and rk_idx stable while rk_valid=1 and rk_ready=0, for any length of backpressure.
REQ-017 On each handshake with rk_idx<10, SHALL show the next round key from the next cycle, with rk_valid held at 1; throughput is 1 key per cycle while rk_ready=1.
REQ-018 On the handshake for the last key, SHALL go to IDLE, drive rk_valid=0 and pulse done=1 for exactly 1 cycle.
REQ-019 SHALL ignore start while busy=1, including in the cycle of the final handshake; a new start is accepted no earlier than the first IDLE cycle.
REQ-020 SHALL keep rk_out at its last value in IDLE; its value in IDLE carries no meaning.

Reset
REQ-021 Asserting rst_n=0 SHALL immediately force IDLE, rk_valid=0, done=0, busy=0, rk_idx=0, rk_out=0 and Rcon=01, regardless of the clock.
REQ-022 A reset in the middle of an expansion SHALL drop the expansion with no done pulse; the first start after reset SHALL behave as in REQ-015.
REQ-023 Leaving reset SHALL need no clock edges before the block accepts start.

Configuration
REQ-024 With macro AES_KEY_EXPAND_REVERSE_EN defined, the block SHALL:
- contain an 11 x 128-bit key buffer;
- on start, enter EXPAND and write one round key per cycle for 11 cycles, with rk_valid=0;
- then enter EMIT, first key valid in cycle start+12, emitted in the order 10 down to 0 for decryption;
- take done on the handshake of round 0.
REQ-025 With AES_KEY_EXPAND_REVERSE_EN undefined, the block SHALL contain no key buffer and no EXPAND state, and SHALL operate in forward mode as in REQ-015 to REQ-018.

Verification
REQ-026 Forward mode: key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_idx 0..10 on consecutive cycles; round 1 key a0fafe1788542cb123a339392a6c7605; round 10 key d014f9a8c9ee2589e13f0cc8b6630ca6; done 1 cycle after round 10.
REQ-027 Backpressure: same key, rk_ready random 30% high -> rk_out stable while stalled; all 11 keys match FIPS-197; no key lost or repeated.
REQ-028 Start while busy: pulse start with key_in=0 during round 5 -> sequence continues with the original key; done fires once.
REQ-029 Reset in mid-run: rst_n=0 at round 4 -> rk_valid=0 and rk_out=0 at once; next start with the same key -> round 0 after 1 cycle, full correct sequence.
REQ-030 Reverse mode (macro defined): same key -> rk_valid=0 for 11 cycles, then round 10 d014f9a8c9ee2589e13f0cc8b6630ca6 first and round 0 2b7e151628aed2a6abf7158809cf4f3c last; done after round 0.
